// File: rtl/spi_master_wb_if.sv
// Wishbone bus bundle for spi_master_wb; signal names follow the slave's view of the bus.
interface spi_master_wb_if;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_int_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_int_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_int_o
  );
endinterface

// File: rtl/spi_master_wb.sv
// Wishbone-slave SPI master with a shared TX/RX shift register.
// Define SPI_WIDE_EN for a 128-bit shift register (TX/RX0-3); default is 32-bit (TX/RX0 only).
module spi_master_wb #(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned SS_W  = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  spi_master_wb_if.slave  wb,
  output logic [SS_W-1:0] ss_pad_o,
  output logic            sclk_pad_o,
  output logic            mosi_pad_o,
  input  logic            miso_pad_i
);

`ifdef SPI_WIDE_EN
  localparam int unsigned LenW = 7;
`else
  localparam int unsigned LenW = 5;
`endif
  localparam int unsigned ShiftW = 1 << LenW;
  localparam int unsigned CntW   = LenW + 1;
  localparam int unsigned Words  = ShiftW / 32;

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e            state_q;
  logic [ShiftW-1:0] shift_q;
  logic [LenW-1:0]   char_len_q;
  logic              rx_neg_q, tx_neg_q, lsb_q, ie_q, ass_q;
  logic [DIV_W-1:0]  divider_q, cnt_q;
  logic [SS_W-1:0]   ss_q;
  logic              sclk_q, mosi_q, ack_q, int_q;
  logic [31:0]       dat_q;
  logic [CntW-1:0]   tx_cnt_q, rx_cnt_q;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] sel);
    logic [31:0] mask;
    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old & ~mask) | (dat & mask);
  endfunction

  // Bus decode
  logic        go_bsy, req, acc, wr;
  logic [2:0]  reg_sel;
  logic [31:0] ctrl_rd, ctrl_new, shift_word, rdata;

  assign go_bsy  = (state_q != StIdle);
  assign req     = wb.wb_cyc_i & wb.wb_stb_i;
  assign acc     = req & ack_q;
  assign wr      = acc & wb.wb_we_i;
  assign reg_sel = wb.wb_adr_i[4:2];
  assign ctrl_rd = {18'd0, ass_q, ie_q, lsb_q, tx_neg_q, rx_neg_q, go_bsy, 1'b0, 7'(char_len_q)};
  assign ctrl_new = merge(ctrl_rd, wb.wb_dat_i, wb.wb_sel_i);

  always_comb begin
    shift_word = '0;
    for (int unsigned w = 0; w < Words; w++) begin
      if (32'(wb.wb_adr_i[3:2]) == w) shift_word = shift_q[32*w +: 32];
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      3'd0, 3'd1, 3'd2, 3'd3: rdata = shift_word;
      3'd4:                   rdata = ctrl_rd;
      3'd5:                   rdata = 32'(divider_q);
      3'd6:                   rdata = 32'(ss_q);
      default:                rdata = '0;
    endcase
  end

  // Transfer bookkeeping
  logic [CntW-1:0] len, len_new, rx_cnt_nxt;
  logic [LenW-1:0] tx_idx, rx_idx, first_idx;
  logic            start, tick, rise, fall, tx_edge, rx_edge, tx_now;

  assign len        = {(char_len_q == '0), char_len_q};
  assign len_new    = {(ctrl_new[LenW-1:0] == '0), ctrl_new[LenW-1:0]};
  assign first_idx  = ctrl_new[11] ? '0 : LenW'(len_new - CntW'(1));
  assign start      = wr && (reg_sel == 3'd4) && !go_bsy && ctrl_new[8];
  assign tick       = (cnt_q == '0);
  assign rise       = tick & ~sclk_q;
  assign fall       = tick & sclk_q;
  assign tx_edge    = tx_neg_q ? fall : rise;
  assign rx_edge    = rx_neg_q ? fall : rise;
  assign rx_cnt_nxt = rx_cnt_q + CntW'(rx_edge);
  assign tx_idx     = lsb_q ? tx_cnt_q[LenW-1:0] : LenW'(len - tx_cnt_q - CntW'(1));
  assign rx_idx     = lsb_q ? rx_cnt_q[LenW-1:0] : LenW'(len - rx_cnt_q - CntW'(1));
  // A new bit goes out only once the previous one has been sampled (or is sampled this edge).
  assign tx_now     = (state_q == StXfer) && tx_edge && (rx_cnt_nxt == tx_cnt_q) &&
                      (tx_cnt_q < len);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      char_len_q <= '0;
      rx_neg_q   <= 1'b0;
      tx_neg_q   <= 1'b0;
      lsb_q      <= 1'b0;
      ie_q       <= 1'b0;
      ass_q      <= 1'b0;
      divider_q  <= '0;
      cnt_q      <= '0;
      ss_q       <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ack_q      <= 1'b0;
      int_q      <= 1'b0;
      dat_q      <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
    end else begin
      ack_q <= req & ~ack_q;
      if (req && !ack_q) dat_q <= rdata;
      if (acc) int_q <= 1'b0;

      if (wr && reg_sel == 3'd6) ss_q <= SS_W'(merge(32'(ss_q), wb.wb_dat_i, wb.wb_sel_i));

      if (wr && !go_bsy) begin
        for (int unsigned w = 0; w < Words; w++) begin
          if (reg_sel == 3'(w)) begin
            shift_q[32*w +: 32] <= merge(shift_q[32*w +: 32], wb.wb_dat_i, wb.wb_sel_i);
          end
        end
        if (reg_sel == 3'd4) begin
          char_len_q <= ctrl_new[LenW-1:0];
          rx_neg_q   <= ctrl_new[9];
          tx_neg_q   <= ctrl_new[10];
          lsb_q      <= ctrl_new[11];
          ie_q       <= ctrl_new[12];
          ass_q      <= ctrl_new[13];
        end
        if (reg_sel == 3'd5) begin
          divider_q <= DIV_W'(merge(32'(divider_q), wb.wb_dat_i, wb.wb_sel_i));
        end
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StXfer;
            cnt_q    <= divider_q;
            sclk_q   <= 1'b0;
            mosi_q   <= shift_q[first_idx];
            tx_cnt_q <= CntW'(1);
            rx_cnt_q <= '0;
          end
        end
        StXfer: begin
          if (tick) begin
            sclk_q <= ~sclk_q;
            cnt_q  <= divider_q;
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
          if (rx_edge) begin
            shift_q[rx_idx] <= miso_pad_i;
            rx_cnt_q        <= rx_cnt_nxt;
            if (rx_cnt_nxt == len) state_q <= StDone;
          end
          if (tx_now) begin
            mosi_q   <= shift_q[tx_idx];
            tx_cnt_q <= tx_cnt_q + CntW'(1);
          end
        end
        StDone: begin
          // Park SCLK low even when the last sample landed on a rising edge.
          sclk_q  <= 1'b0;
          state_q <= StIdle;
          if (ie_q) int_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ss_pad_o    = ~(ass_q ? (ss_q & {SS_W{go_bsy}}) : ss_q);
  assign sclk_pad_o  = sclk_q;
  assign mosi_pad_o  = mosi_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = 1'b0;
  assign wb.wb_int_o = int_q;

  logic unused_bits;
  assign unused_bits = ^{wb.wb_adr_i[1:0], ctrl_new};

endmodule

// File: tb/tb_spi_master_wb.sv
// Directed bench for spi_master_wb: register access, transfer modes, ASS/IE and busy write-protect.
module tb_spi_master_wb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ss_pad;
  logic        sclk, mosi, miso;
  logic        loop_en = 1'b1;
  logic        slave_load = 1'b0;
  logic [31:0] slave_init = '0;
  logic [31:0] slave_sr;
  logic [127:0] bit_log;
  int unsigned edge_cnt;
  int unsigned log_base = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] r;

  spi_master_wb_if bus ();

  spi_master_wb #(.DIV_W(16), .SS_W(8)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst_n),
    .wb         (bus),
    .ss_pad_o   (ss_pad),
    .sclk_pad_o (sclk),
    .mosi_pad_o (mosi),
    .miso_pad_i (miso)
  );

  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : slave_sr[15];

  // Slave model: MSB-first shift on rising SCLK, plus a log of MOSI per rising edge.
  always @(posedge sclk or posedge slave_load) begin
    if (slave_load) begin
      slave_sr <= slave_init;
    end else begin
      slave_sr <= {slave_sr[30:0], mosi};
      bit_log[7'(edge_cnt - log_base)] <= mosi;
      edge_cnt <= edge_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_wait_ack(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = bus.wb_ack_o;
    end
    if (!seen) check({tag, "_ack_timeout"}, 128'(seen), 128'(1));
  endtask

  task automatic wb_write(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    bus.wb_we_i  = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    wb_wait_ack("wr");
    @(posedge clk);
    #1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic wb_read(input logic [4:0] adr, output logic [31:0] dat);
    bus.wb_adr_i = adr;
    bus.wb_sel_i = 4'hF;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    wb_wait_ack("rd");
    dat = bus.wb_dat_o;
    @(posedge clk);
    #1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] c;
    bit idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      wb_read(5'h10, c);
      idle = !c[8];
    end
    check({tag, "_idle"}, 128'(idle), 128'(1));
  endtask

  task automatic rd_check(input string tag, input logic [4:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(adr, d);
    check(tag, 128'(d), 128'(exp));
  endtask

  initial begin
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = '0;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss", 128'(ss_pad), 128'(8'hFF));
    check("rst_sclk", 128'(sclk), 128'(0));
    check("rst_mosi", 128'(mosi), 128'(0));
    check("rst_ack", 128'(bus.wb_ack_o), 128'(0));
    check("rst_int", 128'(bus.wb_int_o), 128'(0));
    check("err_const", 128'(bus.wb_err_o), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd_check("rst_ctrl", 5'h10, 32'h0);
    rd_check("rst_div", 5'h14, 32'h0);

    // Register readback
    wb_write(5'h14, 32'h0000_0001, 4'hF);
    wb_write(5'h00, 32'h0080_0950, 4'hF);
    wb_write(5'h10, 32'h0000_0218, 4'hF);
    wb_write(5'h18, 32'h0000_0001, 4'hF);
    rd_check("rb_div", 5'h14, 32'h1);
    rd_check("rb_tx0", 5'h00, 32'h0080_0950);
    rd_check("rb_ctrl", 5'h10, 32'h218);
    rd_check("rb_ss", 5'h18, 32'h1);
    check("rb_ss_pad", 128'(ss_pad), 128'(8'hFE));
    rd_check("rb_unmapped", 5'h1C, 32'h0);
    rd_check("rb_rx1_zero", 5'h04, 32'h0);
    wb_write(5'h14, 32'hFFFF_ABCD, 4'b0001);
    rd_check("sel_lane0", 5'h14, 32'h0000_00CD);
    wb_write(5'h14, 32'h0000_1200, 4'b0010);
    rd_check("sel_lane1", 5'h14, 32'h0000_12CD);
    wb_write(5'h18, 32'h0, 4'hF);

    // 8-bit MSB-first loopback
    wb_write(5'h14, 32'h1, 4'hF);
    wb_write(5'h00, 32'h0000_00A5, 4'hF);
    wb_write(5'h10, 32'h0000_0208, 4'hF);
    log_base = edge_cnt;
    wb_write(5'h10, 32'h0000_0308, 4'hF);
    wait_idle("msb8");
    rd_check("msb8_rx0", 5'h00, 32'h0000_00A5);
    check("msb8_edges", 128'(edge_cnt - log_base), 128'(8));
    rd_check("msb8_ctrl", 5'h10, 32'h0000_0208);

    // 16-bit LSB-first, TX_NEG, to a preloaded slave
    loop_en = 1'b0;
    slave_init = 32'h0000_5AA5;
    slave_load = 1'b1;
    #1;
    slave_load = 1'b0;
    wb_write(5'h00, 32'h0000_5AA5, 4'hF);
    wb_write(5'h10, 32'h0000_0D10, 4'hF);
    wait_idle("lsb16");
    check("lsb16_slave", 128'(slave_sr[15:0]), 128'(16'hA55A));
    rd_check("lsb16_rx0", 5'h00, 32'h0000_A55A);
    loop_en = 1'b1;

`ifdef SPI_WIDE_EN
    // 64-bit LSB-first across TX1:TX0
    wb_write(5'h14, 32'h0, 4'hF);
    wb_write(5'h00, 32'h7654_3210, 4'hF);
    wb_write(5'h04, 32'hFEDC_BA98, 4'hF);
    log_base = edge_cnt;
    wb_write(5'h10, 32'h0000_0D40, 4'hF);
    wait_idle("lsb64");
    check("lsb64_first32", bit_log[127:0] & 128'hFFFF_FFFF, 128'h7654_3210);
    rd_check("lsb64_rx0", 5'h00, 32'h7654_3210);
    rd_check("lsb64_rx1", 5'h04, 32'hFEDC_BA98);
`endif

    // IE + ASS, 32-bit
    wb_write(5'h14, 32'h2, 4'hF);
    wb_write(5'h00, 32'h3C5A_9617, 4'hF);
    wb_write(5'h10, 32'h0000_3220, 4'hF);
    wb_write(5'h18, 32'h0000_0001, 4'hF);
    check("ass_idle_ss", 128'(ss_pad[0]), 128'(1));
    wb_write(5'h10, 32'h0000_3320, 4'hF);
    check("ass_busy_ss", 128'(ss_pad[0]), 128'(0));
    check("ie_int_low", 128'(bus.wb_int_o), 128'(0));
    for (int i = 0; i < 600 && !bus.wb_int_o; i++) begin
      @(posedge clk);
      #1;
    end
    check("ie_int_rise", 128'(bus.wb_int_o), 128'(1));
    check("ass_done_ss", 128'(ss_pad[0]), 128'(1));
    rd_check("ie_rx0", 5'h00, 32'h3C5A_9617);
    check("ie_int_clr", 128'(bus.wb_int_o), 128'(0));

    // Writes while busy are ignored
    wb_write(5'h18, 32'h0, 4'hF);
    wb_write(5'h10, 32'h0000_0208, 4'hF);
    wb_write(5'h14, 32'h7, 4'hF);
    wb_write(5'h00, 32'h0000_00C3, 4'hF);
    log_base = edge_cnt;
    wb_write(5'h10, 32'h0000_0308, 4'hF);
    wb_write(5'h10, 32'h0000_0210, 4'hF);
    wb_write(5'h00, 32'hFFFF_FFFF, 4'hF);
    wb_write(5'h14, 32'h0, 4'hF);
    rd_check("busy_ctrl", 5'h10, 32'h0000_0308);
    wait_idle("busy");
    rd_check("busy_ctrl_after", 5'h10, 32'h0000_0208);
    rd_check("busy_rx0", 5'h00, 32'h0000_00C3);
    rd_check("busy_div", 5'h14, 32'h7);
    check("busy_edges", 128'(edge_cnt - log_base), 128'(8));

    // Reset mid-transfer
    wb_write(5'h18, 32'h1, 4'hF);
    wb_write(5'h10, 32'h0000_0308, 4'hF);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("midrst_ss", 128'(ss_pad), 128'(8'hFF));
    check("midrst_sclk", 128'(sclk), 128'(0));
    check("midrst_mosi", 128'(mosi), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd_check("midrst_ctrl", 5'h10, 32'h0);
    rd_check("midrst_rx0", 5'h00, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
